adder_seq: RTL and testbench

Multi-byte add sequencer that computes an NBYTES-wide sum with a single external 8-bit ripple adder, one byte per clock, least-significant byte first. It latches operands on a start strobe, drives the byte adder's operand and carry inputs each cycle, and chains the carry through an internal register. It collects the result bytes and reports completion with a one-cycle done pulse. It sits between the control logic that issues wide additions and one instance of the team's 8-bit adder.

---
 rtl/adder_seq.sv | 119 +++++++++++
 tb/tb_adder_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq.sv
// Multi-byte add sequencer: drives one external 8-bit adder a byte per clock, LSB first.
// Optional subtract support is enabled with the ADDSEQ_SUB_EN macro (adds the iSub port).
module adder_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iStart,
  input  logic [8*NBYTES-1:0]   iOp_a,
  input  logic [8*NBYTES-1:0]   iOp_b,
  input  logic                  iC,
`ifdef ADDSEQ_SUB_EN
  input  logic                  iSub,
`endif
  output logic [7:0]            oAdd_a,
  output logic [7:0]            oAdd_b,
  output logic                  oAdd_c,
  input  logic [7:0]            iAdd_s,
  input  logic                  iAdd_c,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [8*NBYTES-1:0]   oSum,
  output logic                  oC,
  output logic                  oOvf
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);
  localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, stateNext;
  logic [KW-1:0]   k;
  logic            creg;
  logic [W-1:0]    opA, opB, acc, sumNext;
  logic [W-1:0]    bEff;
  logic            cEff;
  logic            startAcc, lastByte;

`ifdef ADDSEQ_SUB_EN
  assign bEff = iSub ? ~iOp_b : iOp_b;
  assign cEff = iSub ? 1'b1 : iC;
`else
  assign bEff = iOp_b;
  assign cEff = iC;
`endif

  assign startAcc = (state == IDLE) && iStart;
  assign lastByte = (state == RUN) && (k == KLAST);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iStart) stateNext = RUN;
      RUN:     if (k == KLAST) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    oBusy  = (state != IDLE);
    oDone  = (state == DONE);
    oAdd_a = 8'h00;
    oAdd_b = 8'h00;
    oAdd_c = 1'b0;
    if (state == RUN) begin
      oAdd_a = opA[{k, 3'b000} +: 8];
      oAdd_b = opB[{k, 3'b000} +: 8];
      oAdd_c = creg;
    end
  end

  // Partial result with the current byte merged in; on the last byte this is the full sum
  always_comb begin
    sumNext = acc;
    sumNext[{k, 3'b000} +: 8] = iAdd_s;
  end

  // Control and result registers (cleared by reset and by an accepted start)
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      k     <= '0;
      creg  <= 1'b0;
      oSum  <= '0;
      oC    <= 1'b0;
      oOvf  <= 1'b0;
    end else begin
      state <= stateNext;
      if (startAcc) begin
        k    <= '0;
        creg <= cEff;
        oSum <= '0;
        oC   <= 1'b0;
        oOvf <= 1'b0;
      end else if (state == RUN) begin
        creg <= iAdd_c;
        k    <= lastByte ? '0 : k + 1'b1;
        if (lastByte) begin
          oSum <= sumNext;
          oC   <= iAdd_c;
          oOvf <= (opA[W-1] == opB[W-1]) && (sumNext[W-1] != opA[W-1]);
        end
      end
    end
  end

  // Operand and partial-sum datapath
  always_ff @(posedge iClk) begin
    if (startAcc) begin
      opA <= iOp_a;
      opB <= bEff;
    end
    if (state == RUN) acc <= sumNext;
  end

endmodule

// File: tb/tb_adder_seq.sv
// Scoreboard bench for adder_seq: stimulus pushes whole-word expected results,
// a monitor pops and compares on every oDone. External 8-bit adder modelled inline.
module tb_adder_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rstN, start, c, sub;
  logic [W-1:0]  a, b;
  logic [7:0]    addA, addB, addS;
  logic          addCi, addCo;
  logic          busy, done, cOut, ovf;
  logic [W-1:0]  sum;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  res_t expQ[$];
  res_t mon;
  int   checks = 0;
  int   failures = 0;
  int   dones = 0;
  int   issued = 0;

  always #5 clk = ~clk;

  assign {addCo, addS} = {1'b0, addA} + {1'b0, addB} + {8'h00, addCi};

  adder_seq #(.NBYTES(NB)) dut (
    .iClk   (clk),
    .iRst_n (rstN),
    .iStart (start),
    .iOp_a  (a),
    .iOp_b  (b),
    .iC     (c),
`ifdef ADDSEQ_SUB_EN
    .iSub   (sub),
`endif
    .oAdd_a (addA),
    .oAdd_b (addB),
    .oAdd_c (addCi),
    .iAdd_s (addS),
    .iAdd_c (addCo),
    .oBusy  (busy),
    .oDone  (done),
    .oSum   (sum),
    .oC     (cOut),
    .oOvf   (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    res_t r;
    logic [W:0] full;
    if (s) begin
      r.s = x - y;
      r.c = (x >= y);
      r.v = (x[W-1] != y[W-1]) && (r.s[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r.s  = full[W-1:0];
      r.c  = full[W];
      r.v  = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      if (done) begin
        dones++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got oDone=1 expected no pending result");
        end else begin
          mon = expQ.pop_front();
          check("sum", {32'h0, sum}, {32'h0, mon.s});
          check("carry_out", {63'h0, cOut}, {63'h0, mon.c});
          check("overflow", {63'h0, ovf}, {63'h0, mon.v});
        end
      end
      if (!busy) check("idle_adder_inputs", {47'h0, addA, addB, addCi}, 64'h0);
    end
  end

  task automatic startOp(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts, input bit hold);
    @(negedge clk);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    a = ta; b = tb; c = tc; sub = ts; start = 1'b1;
    expQ.push_back(model(ta, tb, tc, sub));
    issued++;
    @(posedge clk);
    #1;
    check("cleared_on_start", {30'h0, sum, cOut, ovf}, 64'h0);
    check("busy_after_start", {63'h0, busy}, 64'h1);
    if (!hold) start = 1'b0;
  endtask

  task automatic waitDone(input int dropAt, input bit poke, output int lat, output int busyCnt);
    bit seen;
    seen = 0; lat = 0; busyCnt = 0;
    for (int cyc = 1; cyc <= NB + 10 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == dropAt) start = 1'b0;
      if (poke && cyc == 2) begin start = 1'b1; a = 32'hAAAAAAAA; b = 32'h55555555; end
      if (poke && cyc == 3) start = 1'b0;
      if (busy) busyCnt++;
      if (done) begin seen = 1; lat = cyc; end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no oDone within %0d cycles expected one", NB + 10);
    end
  endtask

  task automatic runOp(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts, input bit poke);
    int   lat, bc;
    res_t r;
    r = model(ta, tb, tc, ts);
    startOp(ta, tb, tc, ts, 0);
    waitDone(0, poke, lat, bc);
    check("done_latency", lat, NB + 1);
    check("busy_cycles", bc, NB + 1);
    @(negedge clk);
    check("busy_fell", {63'h0, busy}, 64'h0);
    check("sum_held", {32'h0, sum}, {32'h0, r.s});
  endtask

  initial begin
    int   lat, bc;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    rstN = 1'b0; start = 1'b0; a = '0; b = '0; c = 1'b0; sub = 1'b0;
    #1;
    check("reset_outputs", {11'h0, busy, done, sum, cOut, ovf, addA, addB, addCi}, 64'h0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    runOp(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);
    runOp(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    runOp(32'h12345678, 32'h11111111, 1'b1, 1'b0, 0);
    runOp(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    runOp(32'h80000000, 32'h80000000, 1'b0, 1'b0, 0);
    runOp(32'h00000001, 32'h00000002, 1'b0, 1'b0, 1);
`ifdef ADDSEQ_SUB_EN
    runOp(32'd5, 32'd7, 1'b0, 1'b1, 0);
    runOp(32'd7, 32'd5, 1'b0, 1'b1, 0);
`endif

    // Abort in the third RUN cycle
    startOp(32'hDEADBEEF, 32'h01020304, 1'b1, 1'b0, 0);
    repeat (2) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    check("reset_abort_outputs", {11'h0, busy, done, sum, cOut, ovf, addA, addB, addCi}, 64'h0);
    void'(expQ.pop_back());
    issued--;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    runOp(32'h00000010, 32'h00000020, 1'b0, 1'b0, 0);

    // Start held high: second operation accepted in the first IDLE cycle after DONE
    startOp(32'h01010101, 32'h02020202, 1'b0, 1'b0, 1);
    waitDone(0, 0, lat, bc);
    check("held_first_latency", lat, NB + 1);
    expQ.push_back(model(32'h01010101, 32'h02020202, 1'b0, 1'b0));
    issued++;
    waitDone(2, 0, lat, bc);
    check("held_spacing", lat, NB + 2);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
`ifdef ADDSEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      if (i % 4 == 0) rb = ~ra;
      runOp(ra, rb, rc, rs, 0);
    end

    repeat (3) @(negedge clk);
    check("done_count", dones, issued);
    check("queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
